// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and
// the bit-counter width helper.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must be able to hold WIDTH, hence WIDTH+1 codes.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, bout is the borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, sharing one full-subtractor cell over WIDTH
// clocks, with valid/ready handshakes on both sides.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for an operand pair
//   RUN   | one bit per clock through the shared cell
//   DONE  | result held with out_valid high until out_ready
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             br;
    logic             d_bit;
    logic             br_next;

    full_subtractor u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (br_next)
    );

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            a_sr      <= '0;
            b_sr      <= '0;
            br        <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        br    <= 1'b0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    br   <= br_next;
                    // New bit enters at the MSB so diff is LSB-aligned after WIDTH shifts.
                    diff <= (diff >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        borrow    <= br_next;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and sweep checks for serial_subtractor at WIDTH=4 and WIDTH=1.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       in_valid = 1'b0, out_ready = 1'b0;
    logic [3:0] a = '0, b = '0;
    logic       in_ready, out_valid, borrow;
    logic [3:0] diff;

    logic       in_valid1 = 1'b0, out_ready1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       in_ready1, out_valid1, borrow1;
    logic [0:0] diff1;

    int n_cmp = 0;
    int n_err = 0;
    int acc_cnt = 0;
    int hs_cnt = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow(borrow)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .diff(diff1), .borrow(borrow1)
    );

    always @(posedge clk) begin
        if (!rst && in_valid && in_ready) acc_cnt++;
        if (!rst && out_valid && out_ready) hs_cnt++;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] va;
        logic [3:0] vb;
        logic [3:0] ed;
        logic       eb;
    } vec4_t;

    typedef struct {
        logic [0:0] va;
        logic [0:0] vb;
        logic [0:0] ed;
        logic       eb;
    } vec1_t;

    // Accept one pair on the WIDTH=4 instance; a/b are scrambled after capture.
    task automatic run_op4(input logic [3:0] va, input logic [3:0] vb,
                           input logic [3:0] ed, input logic eb,
                           input string nm, input logic rdy);
        int n;
        @(negedge clk);
        a = va; b = vb; in_valid = 1'b1; out_ready = rdy;
        check({nm, " in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0; a = ~va; b = ~vb;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({nm, " latency"}, n, 4);
        check({nm, " diff"}, 32'(diff), 32'(ed));
        check({nm, " borrow"}, 32'(borrow), 32'(eb));
        if (rdy) begin
            @(negedge clk);
            check({nm, " in_ready_back"}, 32'(in_ready), 32'd1);
            check({nm, " out_valid_drop"}, 32'(out_valid), 32'd0);
        end
    endtask

    task automatic run_op1(input logic [0:0] va, input logic [0:0] vb,
                           input logic [0:0] ed, input logic eb, input string nm);
        int n;
        @(negedge clk);
        a1 = va; b1 = vb; in_valid1 = 1'b1; out_ready1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0; a1 = ~va; b1 = ~vb;
        n = 0;
        while (!out_valid1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({nm, " latency"}, n, 1);
        check({nm, " diff"}, 32'(diff1), 32'(ed));
        check({nm, " borrow"}, 32'(borrow1), 32'(eb));
        @(negedge clk);
        check({nm, " in_ready_back"}, 32'(in_ready1), 32'd1);
    endtask

    initial begin
        vec4_t tab4[8];
        vec1_t tab1[4];
        int    n;
        int    acc0, hs0;
        logic  seen;

        tab4[0] = '{4'd9,  4'd3,  4'h6, 1'b0};
        tab4[1] = '{4'd3,  4'd9,  4'hA, 1'b1};
        tab4[2] = '{4'd0,  4'd1,  4'hF, 1'b1};
        tab4[3] = '{4'd15, 4'd15, 4'h0, 1'b0};
        tab4[4] = '{4'd7,  4'd0,  4'h7, 1'b0};
        tab4[5] = '{4'd8,  4'd9,  4'hF, 1'b1};
        tab4[6] = '{4'd5,  4'd10, 4'hB, 1'b1};
        tab4[7] = '{4'd15, 4'd0,  4'hF, 1'b0};

        tab1[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        tab1[1] = '{1'b0, 1'b1, 1'b1, 1'b1};
        tab1[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
        tab1[3] = '{1'b1, 1'b1, 1'b0, 1'b0};

        #3;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset diff", 32'(diff), 32'd0);
        check("reset borrow", 32'(borrow), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset w1 out_valid", 32'(out_valid1), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run_op4(tab4[i].va, tab4[i].vb, tab4[i].ed, tab4[i].eb, $sformatf("vec%0d", i), 1'b1);

        // Backpressure: result held in DONE while a new pair is offered.
        run_op4(4'd6, 4'd2, 4'h4, 1'b0, "bp", 1'b0);
        for (int i = 0; i < 5; i++) begin
            a = 4'd1; b = 4'd2; in_valid = 1'b1;
            @(negedge clk);
            check($sformatf("bp hold%0d diff", i), 32'(diff), 32'h4);
            check($sformatf("bp hold%0d borrow", i), 32'(borrow), 32'd0);
            check($sformatf("bp hold%0d in_ready", i), 32'(in_ready), 32'd0);
            check($sformatf("bp hold%0d out_valid", i), 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("bp release out_valid", 32'(out_valid), 32'd0);
        check("bp release in_ready", 32'(in_ready), 32'd1);
        check("bp retained diff", 32'(diff), 32'h4);
        run_op4(4'd1, 4'd2, 4'hF, 1'b1, "bp next", 1'b1);

        // Reset two cycles into a 12-5 operation.
        @(negedge clk);
        a = 4'd12; b = 4'd5; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst diff", 32'(diff), 32'd0);
        check("midrst borrow", 32'(borrow), 32'd0);
        check("midrst in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("midrst no stale result", 32'(seen), 32'd0);
        run_op4(4'd5, 4'd5, 4'h0, 1'b0, "after rst", 1'b1);

        // Exhaustive sweep with random consumer stalls.
        acc0 = acc_cnt;
        hs0 = hs_cnt;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                logic [3:0] exp_d;
                exp_d = 4'(ia - ib);
                @(negedge clk);
                a = 4'(ia); b = 4'(ib); in_valid = 1'b1; out_ready = 1'b0;
                @(negedge clk);
                in_valid = 1'b0;
                n = 0;
                while (!out_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                check($sformatf("sweep %0d-%0d", ia, ib), {27'd0, out_valid, diff},
                      {27'd0, 1'b1, exp_d});
                check($sformatf("sweep %0d-%0d borrow", ia, ib), 32'(borrow),
                      32'(ia < ib));
                repeat ($urandom_range(0, 3)) @(negedge clk);
                out_ready = 1'b1;
                @(negedge clk);
                out_ready = 1'b0;
            end
        end
        check("sweep accepts", acc_cnt - acc0, 256);
        check("sweep handshakes", hs_cnt - hs0, 256);

        for (int i = 0; i < 4; i++)
            run_op1(tab1[i].va, tab1[i].vb, tab1[i].ed, tab1[i].eb, $sformatf("w1 vec%0d", i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
